readout_capture: RTL and testbench

- Downstream consumer of the 8-bit readout address generator: it takes the generator's `addr`/`running` pair plus the read data returned by the sample memory.
- Aligns each address with its memory data across the memory's read latency and tags frame boundaries.
- Buffers samples in a first-word-fall-through FIFO and presents them on a valid/ready stream for the serializer/host-link stage that follows.

---
 rtl/readout_capture.sv | 162 ++++++++++++++++
 tb/tb_readout_capture.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/readout_capture.sv
// readout_capture
//   Consumer stage behind the 8-bit readout address generator. It lines up
//   each requested address with the sample memory's read data, which arrives
//   RD_LAT cycles later. Each sample is tagged with frame first/last flags and
//   buffered in a first-word-fall-through FIFO. The FIFO head is offered on a
//   valid/ready stream.
//
// Parameters
//   DATA_W  width of memory read data and stream data
//   RD_LAT  memory read latency in clocks (1..4)
//   DEPTH   FIFO depth in entries (power of 2, 4..256)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   running    generator status; every high cycle requests one sample
//   addr       generator address for the current cycle
//   rd_data    memory data for the address presented RD_LAT cycles earlier
//   out_ready  downstream accepts the head word
//   out_valid  FIFO not empty
//   out_data   head sample data
//   out_addr   head sample address
//   out_first  head word is the first sample of a frame
//   out_last   head word carries address 8'hFF
//   overflow   sticky: a sample was dropped in the current frame
//   busy       samples in flight in the alignment pipeline or FIFO non-empty
//   frame_cnt  (only with FRAME_CNT_EN) count of popped last-tagged words
//
// Optional feature macro: FRAME_CNT_EN adds the frame_cnt output and counter.

module readout_capture #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              running,
  input  logic [7:0]        addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [7:0]        out_addr,
  output logic              out_first,
  output logic              out_last,
  output logic              overflow,
  output logic              busy
`ifdef FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_W + 10;

  // Alignment pipeline state
  logic              running_prev;
  logic              first_flag;
  logic [RD_LAT-1:0] pipe_valid;
  logic [RD_LAT-1:0] pipe_first;
  logic [7:0]        pipe_addr [RD_LAT];

  // FIFO state
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] head;

  logic       sample_valid;
  logic       sample_first;
  logic       sample_last;
  logic [7:0] sample_addr;
  logic       full;
  logic       push;
  logic       pop;
  logic       drop;

  // A frame starts on the rising edge of running.
  assign first_flag = running & ~running_prev;

  // Delay the request tags by the memory latency so that they meet their data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running_prev <= 1'b0;
      pipe_valid   <= '0;
      pipe_first   <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_addr[i] <= '0;
    end else begin
      running_prev  <= running;
      pipe_valid[0] <= running;
      pipe_first[0] <= first_flag;
      pipe_addr[0]  <= addr;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_first[i] <= pipe_first[i-1];
        pipe_addr[i]  <= pipe_addr[i-1];
      end
    end
  end

  assign sample_valid = pipe_valid[RD_LAT-1];
  assign sample_first = pipe_first[RD_LAT-1];
  assign sample_addr  = pipe_addr[RD_LAT-1];
  assign sample_last  = (sample_addr == 8'hFF);

  // A pop frees a slot in the same cycle, so a full FIFO can still accept
  // a sample while it is being read.
  assign full = (count == CNT_W'(DEPTH));
  assign pop  = out_valid & out_ready;
  assign push = sample_valid & (~full | pop);
  assign drop = sample_valid & full & ~pop;

  // Storage is not reset. Outputs are gated by out_valid, so stale entries
  // are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sample_first, sample_last, sample_addr, rd_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A first-tagged sample clears the flag from the previous frame. If that
  // same sample is dropped, the drop term sets the flag again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow <= 1'b0;
    else     overflow <= drop | (overflow & ~(sample_valid & sample_first));
  end

  assign out_valid = (count != '0);
  assign head      = out_valid ? mem[rd_ptr] : '0;
  assign out_first = head[ENTRY_W-1];
  assign out_last  = head[ENTRY_W-2];
  assign out_addr  = head[DATA_W+7:DATA_W];
  assign out_data  = head[DATA_W-1:0];
  assign busy      = (|pipe_valid) | out_valid;

`ifdef FRAME_CNT_EN
  // Counts frames delivered downstream; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 frame_cnt <= '0;
    else if (pop & out_last) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_readout_capture.sv
// tb_readout_capture
//   Self-checking bench for readout_capture. A queue-based reference model
//   tracks outstanding memory requests and FIFO contents, and every output is
//   compared against it on each falling edge. Honours FRAME_CNT_EN.

module tb_readout_capture;

  localparam int RD_LAT = 1;
  localparam int DEPTH  = 16;

  logic       clk;
  logic       rst;
  logic       running;
  logic [7:0] addr;
  logic [7:0] rd_data;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [7:0] out_addr;
  logic       out_first;
  logic       out_last;
  logic       overflow;
  logic       busy;
`ifdef FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  logic [7:0] key = 8'hA5;

  readout_capture #(.DATA_W(8), .RD_LAT(RD_LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .running(running), .addr(addr), .rd_data(rd_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_addr(out_addr), .out_first(out_first), .out_last(out_last),
    .overflow(overflow), .busy(busy)
`ifdef FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample memory: the content is addr ^ key, returned RD_LAT clocks later.
  logic [7:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= addr ^ key;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign rd_data = rd_pipe[RD_LAT-1];

  // Reference model: requests wait in rq until their data returns, then join
  // fq if there is room (or room is being made by a pop in the same cycle).
  typedef struct {
    int         stamp;
    logic [7:0] addr;
    logic       first;
    logic [7:0] data;
  } req_t;
  typedef struct {
    logic       first;
    logic       last;
    logic [7:0] addr;
    logic [7:0] data;
  } ent_t;

  req_t  rq[$];
  ent_t  fq[$];
  int    stamp = 0;
  logic  prev_run = 1'b0;
  logic  m_ovf = 1'b0;
  logic [15:0] m_fcnt = '0;
  req_t  m_s;
  ent_t  m_e;
  logic  m_have;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rq.delete();
      fq.delete();
      prev_run = 1'b0;
      m_ovf    = 1'b0;
      m_fcnt   = '0;
    end else begin
      m_have = 1'b0;
      if (rq.size() > 0 && rq[0].stamp + RD_LAT == stamp) begin
        m_s    = rq.pop_front();
        m_have = 1'b1;
      end
      if (fq.size() > 0 && out_ready) begin
        m_e = fq.pop_front();
        if (m_e.last) m_fcnt = m_fcnt + 16'd1;
      end
      if (m_have) begin
        if (m_s.first) m_ovf = 1'b0;
        if (fq.size() < DEPTH)
          fq.push_back('{first: m_s.first, last: (m_s.addr == 8'hFF), addr: m_s.addr, data: m_s.data});
        else
          m_ovf = 1'b1;
      end
      if (running)
        rq.push_back('{stamp: stamp, addr: addr, first: !prev_run, data: addr ^ key});
      prev_run = running;
      stamp++;
    end
  end

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic       ev;
    logic [7:0] ed;
    logic [7:0] ea;
    logic       ef;
    logic       el;
    ev = (fq.size() > 0);
    ed = ev ? fq[0].data  : 8'h00;
    ea = ev ? fq[0].addr  : 8'h00;
    ef = ev ? fq[0].first : 1'b0;
    el = ev ? fq[0].last  : 1'b0;
    compare("out_valid", 32'(out_valid), 32'(ev));
    compare("out_data",  32'(out_data),  32'(ed));
    compare("out_addr",  32'(out_addr),  32'(ea));
    compare("out_first", 32'(out_first), 32'(ef));
    compare("out_last",  32'(out_last),  32'(el));
    compare("overflow",  32'(overflow),  32'(m_ovf));
    compare("busy",      32'(busy),      32'((rq.size() > 0) || (fq.size() > 0)));
`ifdef FRAME_CNT_EN
    compare("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
`endif
  endtask

  // Drive one cycle of inputs from a falling edge, then check at the next one.
  task automatic applyStimulus(input logic run, input logic [7:0] a, input logic rdy);
    running   = run;
    addr      = a;
    out_ready = rdy;
    if (out_valid && out_ready) pops++;
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  // mode 0: ready high, 1: ready low, 2: ready toggles, 3: random ready/gaps
  task automatic runFrame(input int mode);
    logic rdy;
    logic run;
    for (int a = 0; a < 256; a++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'b0;
        2:       rdy = (a % 2 == 0);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      run = (mode == 3) ? ($urandom_range(0, 31) != 0) : 1'b1;
      applyStimulus(run, 8'(a), rdy);
    end
  endtask

  task automatic runIdle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, rdy);
  endtask

  initial begin
    rst = 1'b1; running = 1'b0; addr = 8'h00; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput();
    rst = 1'b0;

    // Full frame with an always-ready consumer
    pops = 0;
    runFrame(0);
    runIdle(6, 1'b1);
    compare("frame0_pops", 32'(pops), 32'd256);

    // Consumer stalled for the whole frame: only the first DEPTH words remain
    key = 8'($urandom);
    runFrame(1);
    runIdle(4, 1'b0);
    compare("stall_overflow", 32'(overflow), 32'd1);
    pops = 0;
    runIdle(DEPTH + 4, 1'b1);
    compare("stall_drain_pops", 32'(pops), 32'(DEPTH));

    // Alternating ready: fills, then pushes and pops together at full
    key = 8'($urandom);
    runFrame(2);
    runIdle(DEPTH * 2 + 4, 1'b1);

    // Overflowed frame followed by a clean frame
    runFrame(1);
    runIdle(2, 1'b0);
    runFrame(0);
    runIdle(6, 1'b1);
    compare("clean_frame_overflow", 32'(overflow), 32'd0);

    // Random consumer and gaps in running
    key = 8'($urandom);
    runFrame(3);
    runIdle(DEPTH * 4, 1'b1);

    // Reset in the middle of a frame
    for (int a = 0; a < 100; a++) applyStimulus(1'b1, 8'(a), 1'($urandom_range(0, 1)));
    running = 1'b1;
    addr    = 8'd100;
    rst     = 1'b1;
    #1;
    checkOutput();
    compare("midreset_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    running = 1'b0;
    rst     = 1'b0;
    runIdle(2, 1'b1);
    runFrame(0);
    runIdle(6, 1'b1);
    runFrame(0);
    runIdle(6, 1'b1);
    runFrame(0);
    runIdle(6, 1'b1);
`ifdef FRAME_CNT_EN
    compare("frame_cnt_three", 32'(frame_cnt), 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
